// File: rtl/mac_accumulator.sv
// mac_accumulator: signed int8 x int8 multiply-accumulate with an 18-bit
// symmetric saturating accumulator and a valid/ready result register.
module mac_accumulator #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 18,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat_out,
    output logic [CNT_W-1:0] cnt_out
);
    localparam int P_W = 2 * IN_W;
    localparam logic signed [ACC_W:0] SUM_MAX =
        (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;

    logic                    adv;
    logic                    accept;
    logic                    v1;
    logic                    last1;
    logic signed [P_W-1:0]   p1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sticky;
    logic                    clip;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [ACC_W:0]   sum;

    // A held result freezes the whole pipeline, so nothing is ever dropped.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    always_comb begin
        sum      = {acc[ACC_W-1], acc} + {{(ACC_W+1-P_W){p1[P_W-1]}}, p1};
        clip     = 1'b0;
        acc_next = sum[ACC_W-1:0];
        // Symmetric clamp keeps the most negative code out of the result.
        if (sum > SUM_MAX) begin
            clip     = 1'b1;
            acc_next = SUM_MAX[ACC_W-1:0];
        end else if (sum < SUM_MIN) begin
            clip     = 1'b1;
            acc_next = SUM_MIN[ACC_W-1:0];
        end
        cnt_next = (&cnt) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            last1     <= 1'b0;
            p1        <= '0;
            acc       <= '0;
            sticky    <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            sat_out   <= 1'b0;
            cnt_out   <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            out_valid <= v1 & last1;
            if (accept) begin
                p1    <= P_W'($signed(a)) * P_W'($signed(b));
                last1 <= in_last;
            end
            if (v1) begin
                if (last1) begin
                    acc_out <= acc_next;
                    sat_out <= sticky | clip;
                    cnt_out <= cnt_next;
                    acc     <= '0;
                    sticky  <= 1'b0;
                    cnt     <= '0;
                end else begin
                    acc    <= acc_next;
                    sticky <= sticky | clip;
                    cnt    <= cnt_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed and random runs against a run-level
// reference model of the saturating multiply-accumulate.
module tb_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] acc_out;
    logic        sat_out;
    logic [7:0]  cnt_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        int acc;
        bit sat;
        int cnt;
    } res_t;

    res_t exp_q[$];
    int   m_acc = 0;
    bit   m_sat = 1'b0;
    int   m_cnt = 0;

    mac_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .sat_out   (sat_out),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Run-level model: plain integer sum, pinned to +/-131071 at each term.
    task automatic model_term(input int av, input int bv, input bit l);
        m_acc = m_acc + av * bv;
        if (m_acc > 131071) begin
            m_acc = 131071;
            m_sat = 1'b1;
        end else if (m_acc < -131071) begin
            m_acc = -131071;
            m_sat = 1'b1;
        end
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (l) begin
            exp_q.push_back('{acc: m_acc, sat: m_sat, cnt: m_cnt});
            m_acc = 0;
            m_sat = 1'b0;
            m_cnt = 0;
        end
    endtask

    // One clock: drive, check visible result and handshake, advance model.
    task automatic step(input bit v, input int av, input int bv,
                        input bit l, input bit ordy);
        logic pre_valid;
        logic pre_ready;
        in_valid  = v;
        a         = av[7:0];
        b         = bv[7:0];
        in_last   = l;
        out_ready = ordy;
        #1;
        pre_valid = out_valid;
        pre_ready = in_ready;
        if (!rst) begin
            chk("in_ready", in_ready, !out_valid || ordy);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    chk("sb_acc", $signed(acc_out), exp_q[0].acc);
                    chk("sb_sat", sat_out, exp_q[0].sat);
                    chk("sb_cnt", cnt_out, exp_q[0].cnt);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_acc = 0;
            m_sat = 1'b0;
            m_cnt = 0;
        end else begin
            if (pre_valid === 1'b1 && ordy && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (v && pre_ready === 1'b1)
                model_term(av, bv, l);
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, $urandom_range(255), $urandom_range(255), 1'b1, ordy);
    endtask

    // Idle with out_ready low until a result shows, bounded.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            idle(1'b0);
            n++;
        end
        if (out_valid !== 1'b1) chk({tag, "_timeout"}, out_valid, 1);
    endtask

    task automatic expect_result(input string tag, input int acc,
                                 input int sat, input int cnt);
        wait_result(tag);
        chk({tag, "_acc"}, $signed(acc_out), acc);
        chk({tag, "_sat"}, sat_out, sat);
        chk({tag, "_cnt"}, cnt_out, cnt);
        idle(1'b1);
    endtask

    initial begin
        int av;
        int bv;

        // Reset held two cycles with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            step($urandom_range(1), $urandom_range(255) - 128,
                 $urandom_range(255) - 128, $urandom_range(1), 1'b0);
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_acc", $signed(acc_out), 0);
        chk("rst_sat", sat_out, 0);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic run and exact latency
        step(1, 3, 4, 0, 1);
        step(1, -2, 5, 0, 1);
        step(1, 7, 7, 0, 1);
        step(1, -128, -128, 1, 1);
        chk("lat_n", out_valid, 0);
        idle(1'b1);
        chk("lat_n1", out_valid, 1);
        chk("basic_acc", $signed(acc_out), 16435);
        chk("basic_sat", sat_out, 0);
        chk("basic_cnt", cnt_out, 4);
        idle(1'b1);
        chk("basic_one_cycle", out_valid, 0);

        // Positive saturation
        for (int i = 0; i < 9; i++) step(1, 127, 127, i == 8, 1);
        expect_result("pos_sat", 131071, 1, 9);

        // Negative saturation
        for (int i = 0; i < 9; i++) step(1, -128, 127, i == 8, 1);
        expect_result("neg_sat", -131071, 1, 9);

        // Recovery from a pinned value
        for (int i = 0; i < 9; i++) step(1, 127, 127, 0, 1);
        step(1, -1, 1, 1, 1);
        expect_result("recover", 131070, 1, 10);

        // Back-to-back runs under backpressure
        step(1, 5, -3, 1, 0);
        step(1, 2, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 1, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_acc", $signed(acc_out), -15);
            chk("bp_hold_cnt", cnt_out, 1);
            chk("bp_hold_valid", out_valid, 1);
        end
        step(1, 1, 1, 1, 1);
        expect_result("bp_second", 5, 0, 2);

        // Reset in the middle of a run
        step(1, 100, 100, 0, 1);
        step(1, 100, 100, 0, 1);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        step(1, 1, 1, 1, 1);
        expect_result("mid_rst", 1, 0, 1);

        // Term counter saturates at all-ones
        for (int i = 0; i < 299; i++) step(1, 1, 0, 0, 1);
        step(1, 0, 0, 1, 1);
        expect_result("cnt_sat", 0, 0, 255);

        // Random traffic checked by the scoreboard inside step
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            av = $urandom_range(255) - 128;
            bv = $urandom_range(255) - 128;
            step($urandom_range(3) != 0, av, bv, $urandom_range(5) == 0,
                 $urandom_range(9) < 7);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Signed int8 × int8 multiply-accumulate stage for one systolic output column.
- Accumulates a run of products into an 18-bit saturating accumulator.
- Emits each finished sum, with status, over a valid/ready handshake.
- Sits directly upstream of the int18-to-bf16 normaliser; acc_out feeds that block's acc input unchanged.

Parameters:
- IN_W, 8, operand width (signed two's complement).
- ACC_W, 18, accumulator/result width (signed).
- CNT_W, 8, width of the run term counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b valid this cycle.
- in_ready  output  1  block accepts a/b this cycle.
- a  input  IN_W  signed operand A.
- b  input  IN_W  signed operand B.
- in_last  input  1  marks the final term of the current run; qualified by in_valid.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  signed saturated run sum.
- sat_out  output  1  sticky: saturation occurred at least once during the run.
- cnt_out  output  CNT_W  number of terms in the run, saturating at 2^CNT_W-1.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, acc_out=0, sat_out=0, cnt_out=0.
  - Internal accumulator, sticky flag, term counter and stage-1 valid all cleared.
  - Any partial run is discarded.
  - in_ready reads 1 in the cycle after reset deasserts.
- Advance signal: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - All pipeline registers update only when adv=1; when adv=0 every register holds.
- Input accept: in_valid & in_ready at an edge.
- Stage 1 (product register):
  - On accept: p1 = a*b as a signed 2·IN_W product; capture in_last as last1; set v1=1.
  - If adv=1 and no accept: v1=0.
- Stage 2 (accumulate), when adv & v1:
  - sum = acc + sign-extend(p1), computed at ACC_W+1 bits.
  - Symmetric clamp: result limited to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)], i.e. ±131071.
  - -131072 is never produced, so the normaliser's negation cannot overflow.
  - Clamp event sets the sticky flag.
  - Term counter increments, saturating at all-ones.
- Run end (last1=1 at stage 2):
  - acc_out = clamped sum; sat_out = sticky | this-term clamp; cnt_out = counter+1 (saturated); out_valid=1.
  - Internal accumulator, sticky flag and counter reset to 0 at the same edge.
  - The next term starts a fresh run with no bubble.
- Not run end: accumulator := clamped sum; outputs unchanged.
- Output handshake:
  - out_valid & out_ready at an edge consumes the result.
  - out_valid drops unless a new run end completes at that same edge, in which case the new result is loaded and out_valid stays 1.
  - acc_out, sat_out and cnt_out are stable while out_valid=1 and out_ready=0.
- Latency: run-final term accepted at edge N gives out_valid=1 after edge N+1 (2 cycles), with no backpressure.
- Throughput: one term per cycle, including back-to-back runs.
- Backpressure: holding a result stalls the whole pipeline, including a run that is in progress.
  - Guarantees no lost terms and no overwrite of unconsumed results.
- Simultaneous rst with any event: reset wins.
- in_last with in_valid=0 is ignored.
- Data ports are don't-care when in_valid=0.
- Clamped values do not wrap: once pinned, later opposite-sign terms subtract from the clamped value.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> out_valid=0, acc_out=0, sat_out=0, cnt_out=0; in_ready=1 after release.
- Basic run, out_ready=1: (3,4),(-2,5),(7,7),(-128,-128 last) on consecutive cycles -> acc_out=16435, sat_out=0, cnt_out=4; out_valid exactly 2 cycles after the last accept, for 1 cycle.
- Positive saturation: 9×(127,127) -> acc_out=131071, sat_out=1, cnt_out=9.
- Negative saturation: 9×(-128,127) -> acc_out=-131071, sat_out=1.
- Recovery after clamp: 9×(127,127) then (-1,1 last) -> acc_out=131070, sat_out=1, cnt_out=10.
- Back-to-back runs and backpressure:
  - Runs {(5,-3) last} and {(2,2),(1,1) last}, with out_ready=0 for 5 cycles after the first result.
  - Required: first result -15 / cnt 1 held stable; in_ready=0 while held; second result 5 / cnt 2 after release; no term lost.
- Reset mid-run: (100,100),(100,100), then rst=1 for 1 cycle, then (1,1 last) -> acc_out=1, cnt_out=1, sat_out=0.
